// File: rtl/fetch_pkg.sv
// Shared types and field constants for the accumulator-CPU fetch sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fetch_pkg;

    localparam int WORD_W     = 16;
    localparam int OPCODE_MSB = 15;
    localparam int OPCODE_LSB = 12;
    localparam int OPERAND_W  = 12;

    // One state per register-transfer step of the classic fetch sequence.
    typedef enum logic [2:0] {
        S_MAR  = 3'd0,
        S_READ = 3'd1,
        S_MBR  = 3'd2,
        S_IR   = 3'd3,
        S_HOLD = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter: sync reset to RESET_PC, load (jump) beats increment, wraps at 16'hFFFF.
// Latency: pc_o reflects load/increment one clock after the request.
// Backpressure: none; load_i and inc_i are acted on every cycle they are high.
// Ports: clk, reset (sync, active-high), load_i/load_addr_i (jump target),
//        inc_i (advance by one), pc_o (current PC).
module fetch_pc_reg
    import fetch_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = 16'h0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic [WORD_W-1:0] load_addr_i,
    input  logic              inc_i,
    output logic [WORD_W-1:0] pc_o
);

    logic [WORD_W-1:0] pc_q;
    logic [WORD_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_addr_i;
        end else if (inc_i) begin
            pc_d = pc_q + 16'd1;   // unsigned, naturally wraps to zero
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

`ifndef SYNTHESIS
    // Simulation-only notice when an increment carries out of the top address.
    always @(posedge clk) begin
        if (!reset && inc_i && !load_i && (pc_q == 16'hFFFF)) begin
            $display("Program Counter overflow");
        end
    end
`endif

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch sequencer: MAR<-PC, read, MBR<-M[MAR], IR<-MBR/PC+1, present to execute.
// Latency: instr_valid rises 4 cycles after S_MAR entry; 5 cycles per instruction back-to-back.
// Backpressure: holds the word in S_HOLD until instr_ready; no new fetch is issued meanwhile.
// Ports: clk, reset (sync, active-high); mem_addr/mem_rd_en/mem_rdata to sync memory;
//        instr_valid/instr_ready with instr_word/opcode/operand/pc to execute;
//        redirect/redirect_addr (jump), halt (stall before next fetch).
// Optional: define FETCH_COUNT_EN to add a saturating handshake counter on fetch_count.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 14,
    parameter logic [WORD_W-1:0] RESET_PC = 16'h0000
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic                  mem_rd_en,
    input  logic [WORD_W-1:0]     mem_rdata,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [WORD_W-1:0]     instr_word,
    output logic [3:0]            instr_opcode,
    output logic [OPERAND_W-1:0]  instr_operand,
    output logic [WORD_W-1:0]     instr_pc,
`ifdef FETCH_COUNT_EN
    output logic [15:0]           fetch_count,
`endif
    input  logic                  redirect,
    input  logic [WORD_W-1:0]     redirect_addr,
    input  logic                  halt
);

    fetch_state_t      state_q, state_d;
    logic [WORD_W-1:0] mar_q, mar_d;
    logic [WORD_W-1:0] mbr_q, mbr_d;
    logic [WORD_W-1:0] ir_q, ir_d;
    logic [WORD_W-1:0] ipc_q, ipc_d;
    logic [WORD_W-1:0] pc;
    logic              pc_inc;
    logic              handshake;

    fetch_pc_reg #(
        .RESET_PC    (RESET_PC)
    ) u_pc (
        .clk         (clk),
        .reset       (reset),
        .load_i      (redirect),
        .load_addr_i (redirect_addr),
        .inc_i       (pc_inc),
        .pc_o        (pc)
    );

    always_comb begin
        state_d = state_q;
        mar_d   = mar_q;
        mbr_d   = mbr_q;
        ir_d    = ir_q;
        ipc_d   = ipc_q;
        pc_inc  = 1'b0;
        unique case (state_q)
            S_MAR: begin
                // Halt is only honoured here, so a fetch already underway always finishes.
                if (!halt) begin
                    mar_d   = pc;
                    state_d = S_READ;
                end
            end
            S_READ: state_d = S_MBR;
            S_MBR: begin
                mbr_d   = mem_rdata;
                state_d = S_IR;
            end
            S_IR: begin
                ir_d    = mbr_q;
                ipc_d   = mar_q;
                pc_inc  = 1'b1;
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (instr_ready) begin
                    state_d = S_MAR;
                end
            end
            default: state_d = S_MAR;
        endcase
        // A jump abandons whatever is in flight; a word only becomes visible via S_HOLD,
        // so restarting at S_MAR is enough to guarantee discarded content never shows.
        if (redirect) begin
            state_d = S_MAR;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_MAR;
            mar_q   <= '0;
            mbr_q   <= '0;
            ir_q    <= '0;
            ipc_q   <= '0;
        end else begin
            state_q <= state_d;
            mar_q   <= mar_d;
            mbr_q   <= mbr_d;
            ir_q    <= ir_d;
            ipc_q   <= ipc_d;
        end
    end

    assign mem_addr      = mar_q[ADDR_W-1:0];
    assign mem_rd_en     = (state_q == S_READ);
    assign instr_valid   = (state_q == S_HOLD);
    assign instr_word    = ir_q;
    assign instr_opcode  = ir_q[OPCODE_MSB:OPCODE_LSB];
    assign instr_operand = ir_q[OPERAND_W-1:0];
    assign instr_pc      = ipc_q;
    assign handshake     = instr_valid && instr_ready;

`ifdef FETCH_COUNT_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (handshake && (cnt_q != 16'hFFFF)) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign fetch_count = cnt_q;
`else
    logic unused_handshake;
    assign unused_handshake = handshake;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, hand sequences, random run.
// Latency: n/a.
// Backpressure: drives instr_ready low/high to exercise holding.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic [13:0] mem_addr;
    logic        mem_rd_en;
    logic [15:0] mem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr_word;
    logic [3:0]  instr_opcode;
    logic [11:0] instr_operand;
    logic [15:0] instr_pc;
    logic        redirect;
    logic [15:0] redirect_addr;
    logic        halt;
`ifdef FETCH_COUNT_EN
    logic [15:0] fetch_count;
`endif

    int total = 0;
    int bad   = 0;

    logic [15:0] mem [0:16383];

    fetch_unit dut (
`ifdef FETCH_COUNT_EN
        .fetch_count   (fetch_count),
`endif
        .clk           (clk),
        .reset         (reset),
        .mem_addr      (mem_addr),
        .mem_rd_en     (mem_rd_en),
        .mem_rdata     (mem_rdata),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_word    (instr_word),
        .instr_opcode  (instr_opcode),
        .instr_operand (instr_operand),
        .instr_pc      (instr_pc),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .halt          (halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memory: data appears the cycle after the read strobe.
    initial mem_rdata = 16'h0000;
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        total++;
        bad++;
        $display("FAIL %s timed out", nm);
    endtask

    // Returns at the negedge where instr_valid is seen; n = negedges waited (0 = first one).
    task automatic wait_valid(input string nm, output int n);
        n = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (instr_valid) begin
                n = i;
                break;
            end
        end
        if (n < 0) timeout(nm);
    endtask

    task automatic wait_rd(input string nm, output int n);
        n = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mem_rd_en) begin
                n = i;
                break;
            end
        end
        if (n < 0) timeout(nm);
    endtask

    // Leaves the DUT in its first S_MAR cycle with all inputs quiet.
    task automatic do_reset();
        reset = 1'b1;
        redirect = 1'b0;
        redirect_addr = 16'h0000;
        halt = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    typedef struct {
        logic        exp_valid;
        logic        exp_rd;
        logic [13:0] exp_addr;
        logic [15:0] exp_word;
        logic [15:0] exp_pc;
    } vec_t;

    vec_t tbl [15];

    initial begin
        int n;
        logic [15:0] words [3];
        logic [15:0] model_pc;
        logic [15:0] w;
        logic        pv, pr, prd;
        logic [15:0] pw, ppc;
        int          hs;

        words[0] = 16'h1004;
        words[1] = 16'h3005;
        words[2] = 16'h2006;
        for (int i = 0; i < 15; i++) begin
            tbl[i].exp_valid = ((i % 5) == 4);
            tbl[i].exp_rd    = ((i % 5) == 1);
            tbl[i].exp_addr  = 14'(i / 5);
            tbl[i].exp_word  = words[i / 5];
            tbl[i].exp_pc    = 16'(i / 5);
        end

        for (int i = 0; i < 16384; i++) mem[i] = 16'(i * 40503) ^ 16'hA5C3;
        mem[0] = 16'h1004;
        mem[1] = 16'h3005;
        mem[2] = 16'h2006;

        instr_ready = 1'b1;

        // Reset state.
        reset = 1'b1; redirect = 1'b0; redirect_addr = 16'h0; halt = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_rd_en", {31'b0, mem_rd_en}, 32'd0);
        chk("rst_ipc",   {16'b0, instr_pc}, 32'd0);
        chk("rst_word",  {16'b0, instr_word}, 32'd0);
`ifdef FETCH_COUNT_EN
        chk("rst_count", {16'b0, fetch_count}, 32'd0);
`endif

        // Vector table: three back-to-back fetches from reset with ready held high.
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (i > 0) @(negedge clk);
            else @(negedge clk);
            chk($sformatf("tbl%0d_valid", i), {31'b0, instr_valid}, {31'b0, tbl[i].exp_valid});
            chk($sformatf("tbl%0d_rd", i), {31'b0, mem_rd_en}, {31'b0, tbl[i].exp_rd});
            if (tbl[i].exp_rd)
                chk($sformatf("tbl%0d_addr", i), {18'b0, mem_addr}, {18'b0, tbl[i].exp_addr});
            if (tbl[i].exp_valid) begin
                w = tbl[i].exp_word;
                chk($sformatf("tbl%0d_word", i), {16'b0, instr_word}, {16'b0, w});
                chk($sformatf("tbl%0d_pc", i), {16'b0, instr_pc}, {16'b0, tbl[i].exp_pc});
                chk($sformatf("tbl%0d_opc", i), {28'b0, instr_opcode}, {28'b0, w[15:12]});
                chk($sformatf("tbl%0d_opnd", i), {20'b0, instr_operand}, {20'b0, w[11:0]});
            end
        end

        // Backpressure: hold for 10 cycles in S_HOLD.
        do_reset();
        instr_ready = 1'b0;
        wait_valid("bp_first", n);
        chk("bp_lat", n, 32'd4);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_valid", {31'b0, instr_valid}, 32'd1);
            chk("bp_word", {16'b0, instr_word}, 32'h1004);
            chk("bp_pc", {16'b0, instr_pc}, 32'h0);
            chk("bp_rd", {31'b0, mem_rd_en}, 32'd0);
        end
        @(posedge clk);
        #1 instr_ready = 1'b1;
        @(negedge clk);
        chk("bp_rel_valid", {31'b0, instr_valid}, 32'd1);
        @(negedge clk);
        chk("bp_mar_valid", {31'b0, instr_valid}, 32'd0);
        chk("bp_mar_rd", {31'b0, mem_rd_en}, 32'd0);
        @(negedge clk);
        chk("bp_next_rd", {31'b0, mem_rd_en}, 32'd1);
        chk("bp_next_addr", {18'b0, mem_addr}, 32'd1);

        // Redirect while the first fetch is in S_MBR.
        do_reset();
        instr_ready = 1'b1;
        wait_rd("rd_read", n);
        @(posedge clk);
        #1 redirect = 1'b1; redirect_addr = 16'h0040;
        @(posedge clk);
        #1 redirect = 1'b0;
        wait_valid("rd_valid", n);
        chk("rd_lat", n, 32'd4);
        chk("rd_pc", {16'b0, instr_pc}, 32'h0040);
        chk("rd_word", {16'b0, instr_word}, {16'b0, mem[14'h0040]});

        // Wrap at the top of the address space.
        @(posedge clk);
        #1 redirect = 1'b1; redirect_addr = 16'hFFFF;
        @(posedge clk);
        #1 redirect = 1'b0;
        wait_rd("wr_rd", n);
        chk("wr_addr", {18'b0, mem_addr}, 32'h3FFF);
        wait_valid("wr_v1", n);
        chk("wr_pc1", {16'b0, instr_pc}, 32'hFFFF);
        chk("wr_word1", {16'b0, instr_word}, {16'b0, mem[14'h3FFF]});
        wait_valid("wr_v2", n);
        chk("wr_pc2", {16'b0, instr_pc}, 32'h0000);
        chk("wr_word2", {16'b0, instr_word}, 32'h1004);

        // Halt raised in S_HOLD, then handshake.
        do_reset();
        instr_ready = 1'b0;
        wait_valid("h_v0", n);
        halt = 1'b1;
        instr_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("h_valid", {31'b0, instr_valid}, 32'd0);
            chk("h_rd", {31'b0, mem_rd_en}, 32'd0);
        end
        @(posedge clk);
        #1 halt = 1'b0;
        wait_rd("h_resume", n);
        chk("h_resume_lat", n, 32'd1);
        chk("h_resume_addr", {18'b0, mem_addr}, 32'd1);
        wait_valid("h_v1", n);
        chk("h_pc", {16'b0, instr_pc}, 32'd1);

        // Reset asserted in S_READ of the third fetch.
        do_reset();
        instr_ready = 1'b1;
        wait_valid("mr_v0", n);
        wait_valid("mr_v1", n);
        wait_rd("mr_rd", n);
        chk("mr_rd_addr", {18'b0, mem_addr}, 32'd2);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("mr_valid", {31'b0, instr_valid}, 32'd0);
        chk("mr_rd_off", {31'b0, mem_rd_en}, 32'd0);
`ifdef FETCH_COUNT_EN
        chk("mr_count0", {16'b0, fetch_count}, 32'd0);
`endif
        wait_valid("mr_a", n);
        chk("mr_lat", n, 32'd3);
        chk("mr_pc0", {16'b0, instr_pc}, 32'd0);
        wait_valid("mr_b", n);
        wait_valid("mr_c", n);
        chk("mr_pc2", {16'b0, instr_pc}, 32'd2);
        @(negedge clk);
`ifdef FETCH_COUNT_EN
        chk("mr_count3", {16'b0, fetch_count}, 32'd3);
`endif

        // Random run against a transaction-level model: the next presented
        // instruction comes from model_pc; jumps replace it, handshakes advance it.
        do_reset();
        model_pc = 16'h0000;
        hs = 0;
        pv = 1'b0; pr = 1'b0; prd = 1'b0; pw = 16'h0; ppc = 16'h0;
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk);
            #1;
            instr_ready = ($urandom_range(3) != 0);
            halt        = ($urandom_range(15) == 0);
            redirect    = ($urandom_range(24) == 0);
            case ($urandom_range(3))
                0: redirect_addr = 16'hFFFF;
                1: redirect_addr = 16'hFFFE;
                default: redirect_addr = 16'($urandom);
            endcase
            @(negedge clk);
            if (pv && !pr && !prd) begin
                chk("r_hold_valid", {31'b0, instr_valid}, 32'd1);
                chk("r_hold_word", {16'b0, instr_word}, {16'b0, pw});
                chk("r_hold_pc", {16'b0, instr_pc}, {16'b0, ppc});
            end
            if (instr_valid && instr_ready) begin
                w = mem[model_pc[13:0]];
                chk("r_pc", {16'b0, instr_pc}, {16'b0, model_pc});
                chk("r_word", {16'b0, instr_word}, {16'b0, w});
                chk("r_opc", {28'b0, instr_opcode}, {28'b0, w[15:12]});
                hs++;
                model_pc = model_pc + 16'd1;
            end
            if (redirect) model_pc = redirect_addr;
            pv = instr_valid; pr = instr_ready; prd = redirect;
            pw = instr_word; ppc = instr_pc;
        end
        redirect = 1'b0;
        chk("r_progress", {31'b0, (hs > 100)}, 32'd1);
`ifdef FETCH_COUNT_EN
        @(negedge clk);
        chk("r_count", {16'b0, fetch_count}, 32'(hs));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch sequencer directly upstream of the instruction register and execute logic of the 16-bit accumulator CPU.
- Walks the classic MAR <- PC, MBR <- M[MAR], IR <- MBR, PC <- PC+1 sequence against the synchronous main memory.
- Presents the fetched word, its PC and its decoded fields to the execute stage over a valid/ready handshake.
- Accepts jump redirects and a halt request from the execute stage.

Parameters:
- ADDR_W, 14: memory index width; mem_addr = MAR[ADDR_W-1:0] (16Ki-word memory).
- RESET_PC, 16'h0000: PC value loaded on reset.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
- mem_addr  output  ADDR_W  read address to main memory, driven from MAR.
- mem_rd_en  output  1  read strobe; memory returns data on mem_rdata one cycle later.
- mem_rdata  input  16  registered memory read data.
- instr_valid  output  1  fetched instruction available.
- instr_ready  input  1  execute stage accepts the instruction.
- instr_word  output  16  IR contents.
- instr_opcode  output  4  IR[15:12].
- instr_operand  output  12  IR[11:0].
- instr_pc  output  16  address the instruction was fetched from.
- redirect  input  1  jump: discard the in-flight fetch and restart at redirect_addr.
- redirect_addr  input  16  jump target.
- halt  input  1  stop issuing new fetches while high.

Behaviour:
- Reset (synchronous, priority over everything):
  - PC = RESET_PC; MAR, MBR, IR and instr_pc = 0.
  - State = S_MAR.
  - instr_valid = 0, mem_rd_en = 0, fetch_count = 0.
- FSM states, one cycle each unless stated:
  - S_MAR: if halt, stay and leave PC unchanged; else MAR <= PC, go to S_READ.
  - S_READ: mem_rd_en = 1, mem_addr = MAR[ADDR_W-1:0]; go to S_MBR.
  - S_MBR: MBR <= mem_rdata; go to S_IR.
  - S_IR: IR <= MBR, instr_pc <= MAR, PC <= PC+1; go to S_HOLD.
  - S_HOLD: instr_valid = 1. Stay while !instr_ready. On instr_valid && instr_ready go to S_MAR.
- mem_rd_en is 0 in every state except S_READ.
- Latency: 4 cycles from entry to S_MAR until instr_valid rises. Back-to-back throughput is one instruction per 5 cycles with instr_ready held high.
- Handshake rules:
  - instr_word, instr_opcode, instr_operand and instr_pc are stable while instr_valid=1 and !instr_ready.
  - instr_valid never drops without a handshake, except on redirect or reset.
  - instr_valid is a registered (state-decoded) output with no combinational path from instr_ready.
- PC arithmetic:
  - Unsigned 16-bit increment; 16'hFFFF increments to 16'h0000.
  - Simulation-only $display warning "Program Counter overflow" at the wrap.
  - Addresses above 2^ADDR_W-1 alias through truncation in mem_addr.
- Redirect (any state):
  - Next cycle: PC = redirect_addr, state = S_MAR, instr_valid = 0.
  - Any partially fetched MBR/IR content is discarded and never presented.
  - Redirect together with an instr_valid && instr_ready handshake: the handshake counts as completed, and the next fetch comes from redirect_addr.
  - Redirect overrides halt for the PC load. Fetching then waits in S_MAR while halt is high.
- Halt:
  - Sampled only in S_MAR; a fetch already past S_MAR completes and is presented normally.
  - When halt deasserts, fetch resumes from the held PC.
- Reset asserted mid-fetch aborts unconditionally; the first fetch after reset comes from RESET_PC.

Optional Feature:
- Macro FETCH_COUNT_EN.
- Defined: adds output port fetch_count (16 bits), a counter that increments on each instr_valid && instr_ready, saturates at 16'hFFFF, and is cleared by reset.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package fetch_pkg holds:
  - State enum fetch_state_t (S_MAR, S_READ, S_MBR, S_IR, S_HOLD).
  - Constants OPCODE_MSB=15, OPCODE_LSB=12, OPERAND_W=12, WORD_W=16.
- One sub-module, fetch_pc_reg: PC register with synchronous reset to RESET_PC, load (redirect) and increment with wrap plus overflow warning. Load has priority over increment.

Test Plan:
- Reset, with memory[0..2]=16'h1004,16'h3005,16'h2006 and instr_ready=1: instr_valid first rises 4 cycles after reset release. Presented words are 16'h1004 / pc 0 / opcode 1 / operand 12'h004, then 16'h3005 / pc 1, then 16'h2006 / pc 2, spaced 5 cycles apart.
- Backpressure: hold instr_ready=0 for 10 cycles in S_HOLD. instr_word and instr_pc stay constant, no further mem_rd_en pulses occur, and the next fetch starts the cycle after instr_ready rises.
- Redirect: assert redirect with redirect_addr=16'h0040 while in S_MBR. The in-flight word is never presented, and the next instr_pc is 16'h0040.
- Wrap: with redirect_addr=16'hFFFF, the fetch presents instr_pc=16'hFFFF with mem_addr=14'h3FFF, then the following fetch has instr_pc=16'h0000 and the overflow warning is printed.
- Halt: assert halt in S_HOLD, then complete the handshake. The FSM sits in S_MAR with mem_rd_en=0 and PC unchanged. Deassert halt: fetch resumes at the next PC.
- Reset mid-fetch in S_READ: the next cycle shows instr_valid=0, PC=RESET_PC and the state restarts at S_MAR. With FETCH_COUNT_EN defined, fetch_count returns to 0 and equals 3 after three handshakes.
